// File: rtl/seven_seg_pkg.sv
// Shared constants and encode helper for the 7-segment codec.
// Patterns are active-high, bit order gfedcba in [6:0].
package seven_seg_pkg;

  localparam int DP_BIT = 7;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_encode(
    input logic [3:0] digit
  );
    if (digit > 4'd9)
      return SEG_BLANK;
    return SEG_LUT[digit];
  endfunction

endpackage

// File: rtl/seven_seg_if.sv
// Codec data bus: encode in/out and decode in/out.
// master = driver/observer side, slave = codec side.
interface seven_seg_if;

  logic [3:0] dig_in;
  logic       dec_in;
  logic [7:0] seg_out;
  logic [7:0] seg_in;
  logic [3:0] dig_out;
  logic       dec_out;
  logic       invalid;

  modport master (
    output dig_in, dec_in, seg_in,
    input  seg_out, dig_out, dec_out, invalid
  );

  modport slave (
    input  dig_in, dec_in, seg_in,
    output seg_out, dig_out, dec_out, invalid
  );

endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational active-high 7-bit pattern to digit lookup.
// Ports: pattern in; digit out (0 on miss); match out.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       match
);

  always_comb begin
    digit = '0;
    match = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pattern == SEG_LUT[i]) begin
        digit = 4'(i);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_codec.sv
// Registered 7-seg encode and decode, independent 1-cycle pipes.
// Ports: clk, rst_n (async, active-low), bus (seven_seg_if.slave).
module seven_seg_codec
  import seven_seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  seven_seg_if.slave bus
);

  // XOR mask flips a..g only; DP stays active-high.
  localparam logic [6:0] POL =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] seg_norm;
  logic [3:0] dec_digit;
  logic       dec_match;

  assign seg_norm = bus.seg_in[6:0] ^ POL;

  seg_pattern_decode u_dec (
    .pattern (seg_norm),
    .digit   (dec_digit),
    .match   (dec_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_out <= {1'b0, SEG_BLANK ^ POL};
      bus.dig_out <= '0;
      bus.dec_out <= 1'b0;
      bus.invalid <= 1'b1;
    end else begin
      bus.seg_out <= {bus.dec_in,
                      seg_encode(bus.dig_in) ^ POL};
      bus.dig_out <= dec_digit;
      bus.dec_out <= bus.seg_in[DP_BIT];
      bus.invalid <= ~dec_match;
    end
  end

endmodule

// File: tb/tb_seven_seg_codec.sv
// Directed self-checking bench for seven_seg_codec.
// Two instances: active-high (u0) and active-low (u1).
module tb_seven_seg_codec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seven_seg_if bus0 ();
  seven_seg_if bus1 ();

  logic       lb0 = 1'b0;
  logic       lb1 = 1'b0;
  logic [7:0] seg_drv0 = 8'h00;
  logic [7:0] seg_drv1 = 8'h00;

  assign bus0.seg_in = lb0 ? bus0.seg_out : seg_drv0;
  assign bus1.seg_in = lb1 ? bus1.seg_out : seg_drv1;

  seven_seg_codec #(.SEG_ACTIVE_LOW(1'b0)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  seven_seg_codec #(.SEG_ACTIVE_LOW(1'b1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] pat [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.dig_in = 4'($urandom_range(0, 15));
      bus0.dec_in = 1'($urandom_range(0, 1));
      seg_drv0 = 8'($urandom_range(0, 255));
      step();
    end
    tests++;
    if (bus0.seg_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_seg got %h want 00", bus0.seg_out);
    end
    tests++;
    if (bus0.dig_out !== 4'd0 || bus0.dec_out !== 1'b0
        || bus0.invalid !== 1'b1) begin
      fails++;
      $display("FAIL reset_dec got d=%0d p=%b i=%b want 0 0 1",
               bus0.dig_out, bus0.dec_out, bus0.invalid);
    end
    tests++;
    if (bus1.seg_out !== 8'h7F) begin
      fails++;
      $display("FAIL reset_seg_al got %h want 7f", bus1.seg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_encode();
    lb0 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 10; i++) begin
        bus0.dig_in = 4'(i);
        bus0.dec_in = 1'(d);
        step();
        tests++;
        if (bus0.seg_out !== {1'(d), pat[i]}) begin
          fails++;
          $display("FAIL encode_%0d_dp%0d got %h want %h",
                   i, d, bus0.seg_out, {1'(d), pat[i]});
        end
      end
    end
  endtask

  task automatic test_blank();
    lb0 = 1'b1;
    for (int i = 10; i < 16; i++) begin
      bus0.dig_in = 4'(i);
      bus0.dec_in = 1'b1;
      step();
      tests++;
      if (bus0.seg_out !== 8'h80) begin
        fails++;
        $display("FAIL blank_%0d got %h want 80",
                 i, bus0.seg_out);
      end
      step();
      tests++;
      if (bus0.invalid !== 1'b1 || bus0.dig_out !== 4'd0
          || bus0.dec_out !== 1'b1) begin
        fails++;
        $display("FAIL blank_lb_%0d got i=%b d=%0d p=%b want 1 0 1",
                 i, bus0.invalid, bus0.dig_out, bus0.dec_out);
      end
    end
  endtask

  task automatic test_loopback();
    logic [3:0] dv [0:47];
    logic       pv [0:47];
    lb0 = 1'b1;
    for (int c = 0; c < 48; c++) begin
      dv[c] = 4'(c % 16);
      pv[c] = 1'((c / 16) % 2);
      bus0.dig_in = dv[c];
      bus0.dec_in = pv[c];
      step();
      if (c >= 1) begin
        tests++;
        if (dv[c-1] <= 4'd9) begin
          if (bus0.invalid !== 1'b0 || bus0.dig_out !== dv[c-1]
              || bus0.dec_out !== pv[c-1]) begin
            fails++;
            $display("FAIL loop_%0d got i=%b d=%0d p=%b want 0 %0d %b",
                     c, bus0.invalid, bus0.dig_out, bus0.dec_out,
                     dv[c-1], pv[c-1]);
          end
        end else begin
          if (bus0.invalid !== 1'b1 || bus0.dig_out !== 4'd0
              || bus0.dec_out !== pv[c-1]) begin
            fails++;
            $display("FAIL loop_%0d got i=%b d=%0d p=%b want 1 0 %b",
                     c, bus0.invalid, bus0.dig_out, bus0.dec_out,
                     pv[c-1]);
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bad [0:3];
    bad = '{8'h7C, 8'h77, 8'h01, 8'h00};
    lb0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seg_drv0 = bad[i];
      step();
      tests++;
      if (bus0.invalid !== 1'b1 || bus0.dig_out !== 4'd0
          || bus0.dec_out !== 1'b0) begin
        fails++;
        $display("FAIL illegal_%h got i=%b d=%0d p=%b want 1 0 0",
                 bad[i], bus0.invalid, bus0.dig_out, bus0.dec_out);
      end
    end
    seg_drv0 = 8'h86;
    step();
    tests++;
    if (bus0.invalid !== 1'b0 || bus0.dig_out !== 4'd1
        || bus0.dec_out !== 1'b1) begin
      fails++;
      $display("FAIL decode_86 got i=%b d=%0d p=%b want 0 1 1",
               bus0.invalid, bus0.dig_out, bus0.dec_out);
    end
    seg_drv0 = 8'h6F;
    step();
    tests++;
    if (bus0.invalid !== 1'b0 || bus0.dig_out !== 4'd9
        || bus0.dec_out !== 1'b0) begin
      fails++;
      $display("FAIL decode_6f got i=%b d=%0d p=%b want 0 9 0",
               bus0.invalid, bus0.dig_out, bus0.dec_out);
    end
  endtask

  task automatic test_polarity();
    lb1 = 1'b0;
    seg_drv1 = 8'h79;
    bus1.dig_in = 4'd8;
    bus1.dec_in = 1'b0;
    step();
    tests++;
    if (bus1.seg_out !== 8'h00) begin
      fails++;
      $display("FAIL pol_enc8 got %h want 00", bus1.seg_out);
    end
    tests++;
    if (bus1.invalid !== 1'b0 || bus1.dig_out !== 4'd1) begin
      fails++;
      $display("FAIL pol_dec79 got i=%b d=%0d want 0 1",
               bus1.invalid, bus1.dig_out);
    end
    seg_drv1 = 8'h00;
    bus1.dig_in = 4'd1;
    step();
    tests++;
    if (bus1.seg_out !== 8'h79) begin
      fails++;
      $display("FAIL pol_enc1 got %h want 79", bus1.seg_out);
    end
    tests++;
    if (bus1.invalid !== 1'b0 || bus1.dig_out !== 4'd8) begin
      fails++;
      $display("FAIL pol_dec00 got i=%b d=%0d want 0 8",
               bus1.invalid, bus1.dig_out);
    end
    lb1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus1.dig_in = 4'(i);
      bus1.dec_in = 1'(i % 2);
      step();
      step();
      tests++;
      if (bus1.dig_out !== (i <= 9 ? 4'(i) : 4'd0)
          || bus1.invalid !== (i > 9)
          || bus1.dec_out !== 1'(i % 2)) begin
        fails++;
        $display("FAIL pol_loop_%0d got d=%0d i=%b p=%b",
                 i, bus1.dig_out, bus1.invalid, bus1.dec_out);
      end
    end
  endtask

  task automatic test_async_reset();
    lb0 = 1'b1;
    bus0.dig_in = 4'd8;
    bus0.dec_in = 1'b1;
    step();
    step();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus0.seg_out !== 8'h00 || bus0.dig_out !== 4'd0
        || bus0.dec_out !== 1'b0 || bus0.invalid !== 1'b1) begin
      fails++;
      $display("FAIL async_rst got s=%h d=%0d p=%b i=%b",
               bus0.seg_out, bus0.dig_out, bus0.dec_out,
               bus0.invalid);
    end
    tests++;
    if (bus1.seg_out !== 8'h7F) begin
      fails++;
      $display("FAIL async_rst_al got %h want 7f", bus1.seg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus0.dig_in = 4'd3;
    bus0.dec_in = 1'b0;
    step();
    tests++;
    if (bus0.seg_out !== 8'h4F) begin
      fails++;
      $display("FAIL post_rst got %h want 4f", bus0.seg_out);
    end
  endtask

  initial begin
    bus0.dig_in = 4'd0;
    bus0.dec_in = 1'b0;
    bus1.dig_in = 4'd0;
    bus1.dec_in = 1'b0;
    test_reset();
    test_encode();
    test_blank();
    test_loopback();
    test_illegal();
    test_polarity();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
